// File: rtl/qr_proj_ctrl_if.sv
// Handshake bundle between the Gram-Schmidt sequencer and its dot / mul_dot / subtract / norm units.
interface qr_proj_ctrl_if;
  logic        go_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        norm_start_o;
  logic [1:0]  norm_col_o;
  logic        norm_done_i;
  logic        dot_start_o;
  logic [1:0]  dot_col_o;
  logic [1:0]  dot_basis_o;
  logic        dot_done_i;
  logic [15:0] dot_val_i;
  logic        mul_start_o;
  logic [15:0] mul_dot_val_o;
  logic [1:0]  mul_basis_o;
  logic        mul_stop_i;
  logic        sub_valid_o;
  logic [1:0]  sub_col_o;
  logic        sub_ready_i;

  modport master (
    input  go_i, norm_done_i, dot_done_i, dot_val_i, mul_stop_i, sub_ready_i,
    output busy_o, done_o, err_o, norm_start_o, norm_col_o, dot_start_o, dot_col_o,
           dot_basis_o, mul_start_o, mul_dot_val_o, mul_basis_o, sub_valid_o, sub_col_o
  );

  modport slave (
    output go_i, norm_done_i, dot_done_i, dot_val_i, mul_stop_i, sub_ready_i,
    input  busy_o, done_o, err_o, norm_start_o, norm_col_o, dot_start_o, dot_col_o,
           dot_basis_o, mul_start_o, mul_dot_val_o, mul_basis_o, sub_valid_o, sub_col_o
  );
endinterface

// File: rtl/qr_proj_ctrl.sv
// Gram-Schmidt projection sequencer: for each column, project out every earlier basis
// vector (dot, mul_dot scale, subtract), then request normalisation of that column.
module qr_proj_ctrl #(
  parameter int NCOL    = 3,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            reset,
  qr_proj_ctrl_if.master bus
);
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [1:0]    LAST_COL = 2'(NCOL - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_ONE   = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_NORM_REQ  = 4'd1;
  localparam logic [3:0] S_NORM_WAIT = 4'd2;
  localparam logic [3:0] S_DOT_REQ   = 4'd3;
  localparam logic [3:0] S_DOT_WAIT  = 4'd4;
  localparam logic [3:0] S_MUL_REQ   = 4'd5;
  localparam logic [3:0] S_MUL_WAIT  = 4'd6;
  localparam logic [3:0] S_SUB_WAIT  = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  logic [3:0]    state_r, state_nxt_s;
  logic [1:0]    col_r, col_nxt_s;
  logic [1:0]    basis_r, basis_nxt_s;
  logic [15:0]   dval_r, dval_nxt_s;
  logic [CW-1:0] to_cnt, to_cnt_nxt_s;
  logic          err_r, err_nxt_s;

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_nxt_s  = state_r;
    col_nxt_s    = col_r;
    basis_nxt_s  = basis_r;
    dval_nxt_s   = dval_r;
    to_cnt_nxt_s = to_cnt;
    err_nxt_s    = err_r;
    case (state_r)
      S_IDLE: begin
        if (bus.go_i) begin
          col_nxt_s   = 2'd0;
          basis_nxt_s = 2'd0;
          err_nxt_s   = 1'b0;
          state_nxt_s = S_NORM_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_NORM_REQ: state_nxt_s = S_NORM_WAIT;
      S_NORM_WAIT: begin
        if (!bus.norm_done_i) begin
          state_nxt_s = S_NORM_WAIT;
        end else if (col_r == LAST_COL) begin
          state_nxt_s = S_DONE;
        end else begin
          col_nxt_s   = col_r + 2'd1;
          basis_nxt_s = 2'd0;
          state_nxt_s = S_DOT_REQ;
        end
      end
      S_DOT_REQ: state_nxt_s = S_DOT_WAIT;
      S_DOT_WAIT: begin
        if (bus.dot_done_i) begin
          dval_nxt_s  = bus.dot_val_i;
          state_nxt_s = S_MUL_REQ;
        end else begin
          state_nxt_s = S_DOT_WAIT;
        end
      end
      S_MUL_REQ: begin
        to_cnt_nxt_s = {CW{1'b0}};
        state_nxt_s  = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        // The error flag rises as the count hits TIMEOUT; the abort to DONE follows a cycle later.
        if (to_cnt == TO_MAX) begin
          state_nxt_s = S_DONE;
        end else if (bus.mul_stop_i) begin
          state_nxt_s = S_SUB_WAIT;
        end else begin
          to_cnt_nxt_s = to_cnt + TO_ONE;
          if (to_cnt == TO_LAST) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = err_r;
          end
        end
      end
      S_SUB_WAIT: begin
        if (!bus.sub_ready_i) begin
          state_nxt_s = S_SUB_WAIT;
        end else if (basis_r == col_r - 2'd1) begin
          state_nxt_s = S_NORM_REQ;
        end else begin
          basis_nxt_s = basis_r + 2'd1;
          state_nxt_s = S_DOT_REQ;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      col_r   <= 2'd0;
      basis_r <= 2'd0;
      dval_r  <= 16'd0;
      to_cnt  <= {CW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      col_r   <= col_nxt_s;
      basis_r <= basis_nxt_s;
      dval_r  <= dval_nxt_s;
      to_cnt  <= to_cnt_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign bus.busy_o        = (state_r != S_IDLE);
  assign bus.done_o        = (state_r == S_DONE);
  assign bus.err_o         = err_r;
  assign bus.norm_start_o  = (state_r == S_NORM_REQ);
  assign bus.norm_col_o    = col_r;
  assign bus.dot_start_o   = (state_r == S_DOT_REQ);
  assign bus.dot_col_o     = col_r;
  assign bus.dot_basis_o   = basis_r;
  assign bus.mul_start_o   = (state_r == S_MUL_REQ);
  assign bus.mul_dot_val_o = dval_r;
  assign bus.mul_basis_o   = basis_r;
  assign bus.sub_valid_o   = (state_r == S_SUB_WAIT);
  assign bus.sub_col_o     = col_r;
endmodule

// File: doc/qr_proj_ctrl.md
# qr_proj_ctrl

Sequencer for the Gram-Schmidt stage of the QR accelerator. For each column of an NCOL-column matrix it issues the projection sequence (dot product, `mul_dot` scaling, subtract) against every previously normalised basis vector, then requests normalisation of that column. It drives the shared dot-product unit, the `mul_dot` scaler, the subtract/accumulate unit and the norm unit through start/done handshakes. It is the only block that starts `mul_dot`.

## Interface
- NCOL, 3: number of matrix columns; legal range 1..4.
- TIMEOUT, 15: maximum cycles to wait for `mul_stop_i` before flagging an error.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- go_i  in  1  start a decomposition pass; sampled only in IDLE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when a pass completes
- err_o  out  1  sticky `mul_dot` timeout flag; cleared on the next accepted go_i
- norm_start_o  out  1  request normalisation of column norm_col_o
- norm_col_o  out  2  column index for the norm unit
- norm_done_i  in  1  norm unit completion pulse
- dot_start_o  out  1  request dot(column dot_col_o, basis dot_basis_o)
- dot_col_o, dot_basis_o  out  2 each  operand indices
- dot_done_i  in  1  dot unit completion; dot_val_i is valid in the same cycle
- dot_val_i  in  16  dot-product result
- mul_start_o  out  1  start pulse to `mul_dot`
- mul_dot_val_o  out  16  latched dot value presented to `mul_dot`
- mul_basis_o  out  2  selects which q vector feeds `mul_dot`
- mul_stop_i  in  1  `mul_dot` stop
- sub_valid_o  out  1  scaled projection ready for subtraction from sub_col_o
- sub_col_o  out  2  target column
- sub_ready_i  in  1  subtract unit accepts (transfer when valid and ready are both high)

## Operation
- States: IDLE, NORM_REQ, NORM_WAIT, DOT_REQ, DOT_WAIT, MUL_REQ, MUL_WAIT, SUB_WAIT, DONE.
- Registers: col_r and basis_r (2 bits each), dval_r (16 bits), to_cnt (4 bits minimum; wide enough for TIMEOUT).
- IDLE:
  - go_i=1: col_r←0, basis_r←0, err_o←0, go to NORM_REQ.
  - go_i=0 or held high while busy: ignored.
- DOT_REQ / MUL_REQ / NORM_REQ: one cycle each. The matching start output is high only in that state (Moore), then the FSM moves to the matching WAIT state.
- NORM_WAIT, on norm_done_i:
  - col_r==NCOL-1: go to DONE.
  - Otherwise: col_r←col_r+1, basis_r←0, go to DOT_REQ.
- DOT_WAIT, on dot_done_i: dval_r←dot_val_i, go to MUL_REQ.
- MUL_WAIT:
  - to_cnt clears on entry and increments each cycle.
  - mul_stop_i=1: go to SUB_WAIT.
  - to_cnt reaches TIMEOUT first: err_o←1, go to DONE (pass aborted).
- SUB_WAIT: sub_valid_o high. On sub_ready_i:
  - basis_r==col_r-1: go to NORM_REQ.
  - Otherwise: basis_r←basis_r+1, go to DOT_REQ.
- DONE: done_o high for one cycle, then IDLE.
- Index outputs:
  - norm_col_o, dot_col_o and sub_col_o come from col_r.
  - dot_basis_o and mul_basis_o come from basis_r.
  - mul_dot_val_o comes from dval_r.
  - All of these are stable for the whole request/wait episode.
- Column 0 has no projections; the pass goes IDLE → NORM_REQ directly.
- Done/stop inputs are ignored outside their WAIT state. A stray mul_stop_i in any other state has no effect.

## Timing
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; col_r, basis_r, dval_r and to_cnt all 0. Reset mid-pass abandons the pass with no done_o.
- Start and done outputs are registered-state decodes: no combinational path from any input to any output.
- Each handshake episode takes 1 REQ cycle plus N WAIT cycles, where N ≥ 1 is the responder latency. With `mul_dot` (stop one cycle after start), the MUL episode is exactly 2 cycles.
- Pass length with 1-cycle responders and sub_ready_i tied high: 2·NCOL + 5·NCOL(NCOL-1)/2 cycles, plus 1 DONE cycle.
- A back-to-back go_i sampled in the cycle after DONE is accepted.

## Test plan
- NCOL=3, all responders 1-cycle, sub_ready_i=1, go_i pulsed:
  - Operation order is norm0, dot(1,0), mul(b0), sub(1), norm1, dot(2,0), mul(b0), sub(2), dot(2,1), mul(b1), sub(2), norm2.
  - done_o is high exactly 22 cycles after the go_i sampling edge.
  - busy_o is high for cycles 1–22.
- dot_val_i=16'h1234 with dot_done_i: mul_dot_val_o=16'h1234 during MUL_REQ and MUL_WAIT, and mul_start_o is high for exactly one cycle.
- sub_ready_i held low for 5 cycles: sub_valid_o stays high and sub_col_o stays stable; the FSM advances only on the cycle sub_ready_i rises.
- mul_stop_i never asserted, TIMEOUT=15: err_o rises 15 cycles after MUL_WAIT entry; done_o pulses the next cycle; err_o stays 1 until the next go_i.
- reset deasserted→asserted low while in DOT_WAIT: all outputs go to 0 immediately (before the next clock edge); the FSM is in IDLE after release and a new go_i restarts at norm0.
- NCOL=1: go_i produces norm0 only; done_o arrives 3 cycles after go_i is sampled; dot_start_o and mul_start_o never assert.
